// File: rtl/uart_stream_pkg.sv
// Shared types and helpers for the UART word-frame streamer.
// Holds the frame FSM state encoding, the frame sync byte and a counter
// width helper used to size the bit timer, byte counter and channel index.
package uart_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } stream_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART byte serializer.
// A start strobe while idle captures data; the line then carries a start bit,
// eight data bits LSB first and one stop bit, each CLKS_PER_BIT cycles long.
// done pulses for one cycle right after the stop bit period ends.
module uart_tx_serializer
  import uart_stream_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx_serial,
  output logic       active,
  output logic       done
);

  localparam int              TW       = cnt_width(CLKS_PER_BIT);
  localparam logic [TW-1:0]   T_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      STOP_IDX = 4'd9;

  logic [TW-1:0] timer_r;
  logic [3:0]    bit_idx_r;
  logic [8:0]    shift_r;
  logic          last_tick_s;

  // Marks the final cycle of the current bit period.
  always_comb begin
    last_tick_s = (timer_r == T_LAST);
  end

  // Bit timer, bit index and line driver; reset aborts any byte and idles the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_serial <= 1'b1;
      active    <= 1'b0;
      done      <= 1'b0;
      timer_r   <= '0;
      bit_idx_r <= 4'd0;
      shift_r   <= 9'h1FF;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          active    <= 1'b1;
          tx_serial <= 1'b0;
          timer_r   <= '0;
          bit_idx_r <= 4'd0;
          shift_r   <= {1'b1, data};
        end else begin
          tx_serial <= 1'b1;
        end
      end else if (last_tick_s) begin
        timer_r <= '0;
        if (bit_idx_r == STOP_IDX) begin
          active    <= 1'b0;
          done      <= 1'b1;
          tx_serial <= 1'b1;
        end else begin
          // Shifting in ones makes the stop bit fall out after the 8 data bits.
          bit_idx_r <= bit_idx_r + 4'd1;
          tx_serial <= shift_r[0];
          shift_r   <= {1'b1, shift_r[8:1]};
        end
      end else begin
        timer_r <= timer_r + TW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_frame_streamer.sv
// Frame streamer: sends NUM_CH words of BYTES_PER_WORD bytes per frame over
// an 8N1 UART line. Words arrive on a valid/ready handshake; ch_idx tells the
// source which channel the next accepted word belongs to.
// Optional feature macro UART_SYNC_HEADER_EN: prefixes every frame with the
// sync byte 8'hA5 so the host can align without relying on timing.
module uart_tx_frame_streamer
  import uart_stream_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 868,
  parameter int BYTES_PER_WORD = 2,
  parameter int NUM_CH         = 3,
  parameter int MSB_FIRST      = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic                              word_valid,
  input  logic [8*BYTES_PER_WORD-1:0]       word_data,
  output logic                              word_ready,
  output logic [cnt_width(NUM_CH)-1:0]      ch_idx,
  output logic                              tx_serial,
  output logic                              busy,
  output logic                              frame_done
);

  localparam int               WORD_W  = 8 * BYTES_PER_WORD;
  localparam int               BC_W    = cnt_width(BYTES_PER_WORD);
  localparam int               CH_W    = cnt_width(NUM_CH);
  localparam logic [BC_W-1:0]  BC_LAST = BC_W'(BYTES_PER_WORD - 1);
  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NUM_CH - 1);

  stream_state_t     state_r;
  logic [WORD_W-1:0] word_r;
  logic [BC_W-1:0]   byte_cnt_r;
  logic [BC_W-1:0]   sel_s;
  logic [7:0]        word_byte_s;
  logic              ser_start_s;
  logic [7:0]        ser_data_s;
  logic              ser_active_s;
  logic              ser_done_s;
`ifdef UART_SYNC_HEADER_EN
  logic              hdr_r;
`endif

  // Picks the byte lane of the latched word for the current byte position.
  always_comb begin
    if (MSB_FIRST != 0) begin
      sel_s = BC_LAST - byte_cnt_r;
    end else begin
      sel_s = byte_cnt_r;
    end
    word_byte_s = word_r[{sel_s, 3'b000} +: 8];
  end

  // Start strobe and byte presented to the serializer.
  always_comb begin
    ser_start_s = 1'b0;
    ser_data_s  = word_byte_s;
    case (state_r)
      ST_SEND: ser_start_s = !ser_active_s;
`ifdef UART_SYNC_HEADER_EN
      ST_HDR: begin
        ser_start_s = !ser_active_s;
        ser_data_s  = SYNC_BYTE;
      end
`endif
      default: ser_start_s = 1'b0;
    endcase
  end

  assign word_ready = (state_r == ST_FETCH);

  // Frame sequencing: word fetch, byte stepping, channel stepping and frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      word_r     <= '0;
      byte_cnt_r <= '0;
      ch_idx     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef UART_SYNC_HEADER_EN
      hdr_r      <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // enable is only looked at here, so a frame always runs to completion.
          if (enable) begin
            busy       <= 1'b1;
            ch_idx     <= '0;
            byte_cnt_r <= '0;
`ifdef UART_SYNC_HEADER_EN
            state_r    <= ST_HDR;
`else
            state_r    <= ST_FETCH;
`endif
          end
        end
`ifdef UART_SYNC_HEADER_EN
        ST_HDR: begin
          if (!ser_active_s) begin
            hdr_r   <= 1'b1;
            state_r <= ST_WAIT;
          end
        end
`endif
        ST_FETCH: begin
          if (word_valid) begin
            word_r     <= word_data;
            byte_cnt_r <= '0;
            state_r    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!ser_active_s) begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ser_done_s) begin
`ifdef UART_SYNC_HEADER_EN
            if (hdr_r) begin
              hdr_r   <= 1'b0;
              state_r <= ST_FETCH;
            end else
`endif
            if (byte_cnt_r < BC_LAST) begin
              byte_cnt_r <= byte_cnt_r + BC_W'(1);
              state_r    <= ST_SEND;
            end else if (ch_idx < CH_LAST) begin
              ch_idx  <= ch_idx + CH_W'(1);
              state_r <= ST_FETCH;
            end else begin
              frame_done <= 1'b1;
              state_r    <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          ch_idx  <= '0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          ch_idx  <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (ser_start_s),
    .data      (ser_data_s),
    .tx_serial (tx_serial),
    .active    (ser_active_s),
    .done      (ser_done_s)
  );

endmodule

// File: tb/tb_uart_tx_frame_streamer.sv
// Self-checking bench for uart_tx_frame_streamer.
// A line model decodes every byte on the UART line against a queue of
// expected bytes, checking every bit cycle, frame_done timing and busy.
`timescale 1ns/1ps
module tb_uart_tx_frame_streamer;

  localparam int C   = 16;
  localparam int BPB = 10 * C;
`ifdef UART_SYNC_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        enable = 1'b0, word_valid = 1'b0;
  logic [15:0] word_data = 16'h0000;
  logic        word_ready, busy, frame_done, tx;
  logic [1:0]  ch_idx;

  logic        enable2 = 1'b0, word_valid2 = 1'b0;
  logic [31:0] word_data2 = 32'h0;
  logic        word_ready2, busy2, frame_done2, tx2;
  logic [0:0]  ch_idx2;

  uart_tx_frame_streamer #(.CLKS_PER_BIT(C), .BYTES_PER_WORD(2), .NUM_CH(3), .MSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready), .ch_idx(ch_idx), .tx_serial(tx), .busy(busy), .frame_done(frame_done));

  uart_tx_frame_streamer #(.CLKS_PER_BIT(C), .BYTES_PER_WORD(4), .NUM_CH(1), .MSB_FIRST(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable2), .word_valid(word_valid2), .word_data(word_data2),
    .word_ready(word_ready2), .ch_idx(ch_idx2), .tx_serial(tx2), .busy(busy2), .frame_done(frame_done2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- line model ----------------
  logic [7:0] byte_q[$];
  int         start_t[$];
  bit         use2 = 1'b0;
  bit         mon_active = 1'b0;
  int         mon_k = 0;
  logic [7:0] cur_byte = 8'h00;
  int         since_end = 1000;
  bit         end_last = 1'b0;
  int         fd_count = 0;
  int         mon_cyc = 0;
  logic       mline, mfd, mbusy, eb;
  int         bitn;

  initial begin
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (!rst_n) begin
        mon_active = 1'b0;
        since_end  = 1000;
        end_last   = 1'b0;
      end else begin
        mline = use2 ? tx2 : tx;
        mfd   = use2 ? frame_done2 : frame_done;
        mbusy = use2 ? busy2 : busy;
        if (since_end < 1000) since_end++;
        chk("frame_done", mfd, (since_end == 2) && end_last);
        if (mfd) begin
          fd_count++;
          chk("busy_at_done", mbusy, 1);
        end
        if (since_end == 3 && end_last) chk("busy_after_done", mbusy, 0);
        if (mon_active) begin
          bitn = mon_k / C;
          if (bitn == 0) eb = 1'b0;
          else if (bitn == 9) eb = 1'b1;
          else eb = cur_byte[bitn-1];
          chk("tx_bit", mline, eb);
          mon_k++;
          if (mon_k == BPB) begin
            mon_active = 1'b0;
            since_end  = 0;
            end_last   = (byte_q.size() == 0);
          end
        end else if (mline == 1'b0) begin
          if (byte_q.size() == 0) begin
            chk("unexpected_start", mon_cyc, 0);
          end else begin
            cur_byte   = byte_q.pop_front();
            start_t.push_back(mon_cyc);
            mon_active = 1'b1;
            mon_k      = 1;
          end
        end
      end
    end
  end

  // ---------------- word source for dut ----------------
  logic [15:0] src_q[$];
  int          exp_ch = 0;
  bit          acc;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) exp_ch = 0;
      acc = rst_n && word_valid && word_ready;
      if (acc) begin
        chk("ch_idx", ch_idx, exp_ch);
        exp_ch = (exp_ch + 1) % 3;
      end
      @(posedge clk);
      #1;
      if (acc && src_q.size() > 0) void'(src_q.pop_front());
      word_valid = (src_q.size() > 0);
      word_data  = word_valid ? src_q[0] : 16'($urandom);
    end
  end

  // ---------------- helpers ----------------
  task automatic push_frame(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    logic [15:0] w[3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    if (HDR != 0) byte_q.push_back(8'hA5);
    for (int i = 0; i < 3; i++) begin
      byte_q.push_back(w[i][15:8]);
      byte_q.push_back(w[i][7:0]);
      src_q.push_back(w[i]);
    end
  endtask

  task automatic raise_enable();
    int n = 0;
    @(posedge clk);
    #1 enable = 1'b1;
    while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("busy_rise", busy, 1);
  endtask

  task automatic wait_frame(input int budget, input string name);
    int f0 = fd_count;
    int n = 0;
    while (fd_count == f0 && n < budget) begin @(negedge clk); n++; end
    chk(name, fd_count - f0, 1);
    repeat (4) @(negedge clk);
    chk({name, "_bytes_left"}, byte_q.size(), 0);
  endtask

  task automatic check_gaps(input int bpw, input string name);
    for (int i = 1; i < start_t.size(); i++) begin
      chk(name, start_t[i] - start_t[i-1], BPB + ((((i - HDR) % bpw) == 0) ? 3 : 2));
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n;
    int f0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", word_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_ch_idx", ch_idx, 0);
    chk("rst_tx2", tx2, 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Default frame with back-to-back words available.
    push_frame(16'h1234, 16'hABCD, 16'h00FF);
    repeat (3) @(negedge clk);
    raise_enable();
    enable = 1'b0;
    wait_frame(3000, "frame1_done");
    chk("frame1_starts", start_t.size(), 6 + HDR);
    check_gaps(2, "frame1_gap");
    chk("frame1_span", start_t[start_t.size()-1] - start_t[0], (HDR != 0) ? 975 : 812);
    start_t.delete();

    // Source stalls while the streamer waits for the channel 1 word.
    if (HDR != 0) byte_q.push_back(8'hA5);
    byte_q.push_back(8'h01); byte_q.push_back(8'h02);
    byte_q.push_back(8'h80); byte_q.push_back(8'h40);
    byte_q.push_back(8'h7E); byte_q.push_back(8'hE7);
    src_q.push_back(16'h0102);
    repeat (3) @(negedge clk);
    raise_enable();
    enable = 1'b0;
    n = 0;
    while (!(word_ready === 1'b1 && ch_idx === 2'd1) && n < 2000) begin @(negedge clk); n++; end
    chk("stall_reach_ch1", ch_idx, 1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("stall_tx", tx, 1);
      chk("stall_busy", busy, 1);
      chk("stall_ready", word_ready, 1);
    end
    src_q.push_back(16'h8040);
    src_q.push_back(16'h7EE7);
    wait_frame(3000, "stall_done");
    chk("stall_starts", start_t.size(), 6 + HDR);
    start_t.delete();

    // enable dropped after the first byte: frame completes, none follows.
    push_frame(16'h5AC3, 16'h0F1E, 16'hFFFE);
    repeat (3) @(negedge clk);
    raise_enable();
    n = 0;
    while (start_t.size() < 2 && n < 1000) begin @(negedge clk); n++; end
    enable = 1'b0;
    wait_frame(3000, "endrop_done");
    chk("endrop_starts", start_t.size(), 6 + HDR);
    check_gaps(2, "endrop_gap");
    start_t.delete();
    f0 = fd_count;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      chk("endrop_idle_busy", busy, 0);
      chk("endrop_idle_tx", tx, 1);
    end
    chk("endrop_no_frame", fd_count, f0);

    // Single 32-bit word, LSB byte first; source data changes after accept.
    use2 = 1'b1;
    if (HDR != 0) byte_q.push_back(8'hA5);
    byte_q.push_back(8'hEF); byte_q.push_back(8'hBE);
    byte_q.push_back(8'hAD); byte_q.push_back(8'hDE);
    word_data2  = 32'hDEADBEEF;
    word_valid2 = 1'b1;
    @(posedge clk);
    #1 enable2 = 1'b1;
    n = 0;
    while (word_ready2 !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    chk("lsb_ready", word_ready2, 1);
    chk("lsb_ch_idx", ch_idx2, 0);
    @(posedge clk);
    #1;
    word_valid2 = 1'b0;
    word_data2  = 32'h0BADF00D;
    enable2     = 1'b0;
    wait_frame(3000, "lsb_done");
    chk("lsb_starts", start_t.size(), 4 + HDR);
    check_gaps(4, "lsb_gap");
    start_t.delete();
    use2 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during data bit 3 of the first byte.
    push_frame(16'h1234, 16'hABCD, 16'h00FF);
    repeat (3) @(negedge clk);
    raise_enable();
    enable = 1'b0;
    n = 0;
    while (!(mon_active && mon_k >= 4*C + 2 && mon_k < 5*C - 2) && n < 2000) begin @(negedge clk); n++; end
    chk("rst_mid_reached", mon_active, 1);
    #2 rst_n = 1'b0;
    src_q.delete();
    byte_q.delete();
    start_t.delete();
    @(negedge clk);
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", word_ready, 0);
    chk("rst_mid_frame_done", frame_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    f0 = fd_count;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      chk("rst_after_tx", tx, 1);
    end
    chk("rst_after_no_frame", fd_count, f0);
    chk("rst_after_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
